// File: rtl/tof_pkg.sv
// -----------------------------------------------------------------------------
// tof_pkg
// Shared definitions for the ToF record path: streamer FSM states, the packet
// header magic nibble, the default sensor count and the sensor-index type that
// the memory-write stage also uses.
// -----------------------------------------------------------------------------
package tof_pkg;

   localparam int NUM_SENSORS_DEF = 8;
   localparam int TOF_IDX_W       = $clog2(NUM_SENSORS_DEF);

   // High nibble of every packet header byte; low nibble carries the sensor index.
   localparam logic [3:0] HEADER_MAGIC = 4'hA;

   typedef logic [TOF_IDX_W-1:0] tof_idx_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HEADER  = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      SEND    = 3'd4,
      CSUM    = 3'd5
   } tof_state_e;

endpackage

// File: rtl/tof_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tof_rr_arbiter
// Combinational round-robin search: finds the first set bit of pending_i at or
// after rr_ptr_i, wrapping modulo NUM_SENSORS.
// Ports:
//   pending_i      fresh-record flags
//   rr_ptr_i       search start index
//   grant_valid_o  some flag is set
//   grant_idx_o    index of the selected flag (0 when none)
// -----------------------------------------------------------------------------
module tof_rr_arbiter
   import tof_pkg::*;
#(
   parameter  int NUM_SENSORS = NUM_SENSORS_DEF,
   localparam int IDX_W       = $clog2(NUM_SENSORS)
) (
   input  logic [NUM_SENSORS-1:0] pending_i,
   input  logic [IDX_W-1:0]       rr_ptr_i,
   output logic                   grant_valid_o,
   output logic [IDX_W-1:0]       grant_idx_o
);

   // Scan offsets from farthest to nearest so the nearest set bit is the last writer.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
         logic [IDX_W-1:0] cand;
         cand          = rr_ptr_i + IDX_W'(i);
         grant_valid_o = grant_valid_o | pending_i[cand];
         grant_idx_o   = pending_i[cand] ? cand : grant_idx_o;
      end
   end

endmodule

// File: rtl/tof_frame_streamer.sv
// -----------------------------------------------------------------------------
// tof_frame_streamer
// Watches the ToF memory-write stage, flags sensor records that were freshly
// written, reads each flagged record back from the shared BRAM and streams it
// as a byte packet: header (0xA0|idx), record bytes MSB first, XOR checksum.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_wea, wr_index    write enable / sensor index from the write stage
//   mem_en, mem_addr    BRAM read request, address = {sensor, word}
//   mem_dout            BRAM read data, valid RD_LAT cycles after mem_en
//   m_tdata/m_tvalid/m_tready/m_tlast   byte stream to the host-link TX
//   busy                FSM not idle
//   pending             fresh-record flags
// -----------------------------------------------------------------------------
module tof_frame_streamer
   import tof_pkg::*;
#(
   parameter  int NUM_SENSORS      = NUM_SENSORS_DEF,
   parameter  int WORDS_PER_SENSOR = 4,
   parameter  int DATA_W           = 16,
   parameter  int RD_LAT           = 1,
   localparam int IDX_W            = $clog2(NUM_SENSORS),
   localparam int WRD_W            = $clog2(WORDS_PER_SENSOR)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_wea,
   input  logic [IDX_W-1:0]       wr_index,
   output logic                   mem_en,
   output logic [IDX_W+WRD_W-1:0] mem_addr,
   input  logic [DATA_W-1:0]      mem_dout,
   output logic [7:0]             m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic                   busy,
   output logic [NUM_SENSORS-1:0] pending
);

   localparam int BYTES_PER_WORD = DATA_W / 8;
   localparam int BC_W           = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   localparam logic [BC_W-1:0]        BYTE_LAST = BC_W'(BYTES_PER_WORD - 1);
   localparam logic [WRD_W-1:0]       WORD_LAST = WRD_W'(WORDS_PER_SENSOR - 1);
   localparam logic [1:0]             RD_LAT_C  = 2'(RD_LAT);
   localparam logic [NUM_SENSORS-1:0] ONE_HOT0  = {{(NUM_SENSORS-1){1'b0}}, 1'b1};

   tof_state_e             state_q;
   logic [IDX_W-1:0]       sel_idx_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [IDX_W-1:0]       wr_idx_q;
   logic                   wr_wea_q;
   logic [NUM_SENSORS-1:0] pending_q;
   logic [NUM_SENSORS-1:0] pending_d;
   logic [NUM_SENSORS-1:0] set_mask_s;
   logic [NUM_SENSORS-1:0] clr_mask_s;
   logic [WRD_W-1:0]       word_cnt_q;
   logic [BC_W-1:0]        byte_cnt_q;
   logic [1:0]             wait_cnt_q;
   logic [DATA_W-1:0]      buf_q;
   logic [DATA_W-1:0]      buf_shift_s;
   logic [7:0]             csum_q;
   logic [7:0]             csum_next_s;
   logic [7:0]             tdata_q;
   logic                   tvalid_q;
   logic                   tlast_q;
   logic                   mem_en_q;
   logic [IDX_W+WRD_W-1:0] mem_addr_q;
   logic                   grant_valid_s;
   logic [IDX_W-1:0]       grant_idx_s;

   tof_rr_arbiter #(
      .NUM_SENSORS (NUM_SENSORS)
   ) u_arb (
      .pending_i     (pending_q),
      .rr_ptr_i      (rr_ptr_q),
      .grant_valid_o (grant_valid_s),
      .grant_idx_o   (grant_idx_s)
   );

   // Remember the enable history and the index of the burst in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_wea_q <= 1'b0;
         wr_idx_q <= '0;
      end else begin
         wr_wea_q <= wr_wea;
         if (wr_wea) begin
            wr_idx_q <= wr_index;
         end
      end
   end

   // Falling edge of wr_wea flags the record; a grant clears its flag. Set wins a tie.
   always_comb begin
      set_mask_s = '0;
      clr_mask_s = '0;
      if (wr_wea_q && !wr_wea) begin
         set_mask_s = ONE_HOT0 << wr_idx_q;
      end else begin
         set_mask_s = '0;
      end
      if ((state_q == IDLE) && grant_valid_s) begin
         clr_mask_s = ONE_HOT0 << grant_idx_s;
      end else begin
         clr_mask_s = '0;
      end
      pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
   end

   // Fresh-record flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign buf_shift_s = buf_q << 8;
   assign csum_next_s = csum_q ^ tdata_q;

   // Packet FSM; every stream and BRAM output is a register driven from here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sel_idx_q  <= '0;
         rr_ptr_q   <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         wait_cnt_q <= 2'd0;
         buf_q      <= '0;
         csum_q     <= 8'h00;
         tdata_q    <= 8'h00;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid_s) begin
                  sel_idx_q  <= grant_idx_s;
                  rr_ptr_q   <= grant_idx_s + IDX_W'(1);
                  word_cnt_q <= '0;
                  tdata_q    <= {HEADER_MAGIC, 4'(grant_idx_s)};
                  csum_q     <= {HEADER_MAGIC, 4'(grant_idx_s)};
                  tvalid_q   <= 1'b1;
                  state_q    <= HEADER;
               end
            end
            HEADER: begin
               if (m_tready) begin
                  tvalid_q   <= 1'b0;
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= {sel_idx_q, word_cnt_q};
                  state_q    <= RD_REQ;
               end
            end
            RD_REQ: begin
               mem_en_q   <= 1'b0;
               wait_cnt_q <= 2'd1;
               state_q    <= RD_WAIT;
            end
            RD_WAIT: begin
               // Count cycles after the request; data is on mem_dout in the RD_LAT-th.
               if (wait_cnt_q == RD_LAT_C) begin
                  buf_q      <= mem_dout;
                  byte_cnt_q <= '0;
                  tdata_q    <= mem_dout[DATA_W-1 -: 8];
                  tvalid_q   <= 1'b1;
                  state_q    <= SEND;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 2'd1;
               end
            end
            SEND: begin
               if (m_tready) begin
                  csum_q     <= csum_next_s;
                  buf_q      <= buf_shift_s;
                  byte_cnt_q <= byte_cnt_q + BC_W'(1);
                  if (byte_cnt_q == BYTE_LAST) begin
                     if (word_cnt_q == WORD_LAST) begin
                        tdata_q <= csum_next_s;
                        tlast_q <= 1'b1;
                        state_q <= CSUM;
                     end else begin
                        word_cnt_q <= word_cnt_q + WRD_W'(1);
                        tvalid_q   <= 1'b0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {sel_idx_q, word_cnt_q + WRD_W'(1)};
                        state_q    <= RD_REQ;
                     end
                  end else begin
                     tdata_q <= buf_shift_s[DATA_W-1 -: 8];
                  end
               end
            end
            CSUM: begin
               if (m_tready) begin
                  tvalid_q <= 1'b0;
                  tlast_q  <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
               mem_en_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign m_tdata  = tdata_q;
   assign m_tvalid = tvalid_q;
   assign m_tlast  = tlast_q;
   assign mem_en   = mem_en_q;
   assign mem_addr = mem_addr_q;
   assign busy     = (state_q != IDLE);
   assign pending  = pending_q;

endmodule

// File: tb/tb_tof_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_tof_frame_streamer
// Scoreboard bench. u_dut uses RD_LAT=1; u_dut3 uses RD_LAT=3 and is checked on
// the first packet only. Expected bytes are built from the bench's BRAM image.
// -----------------------------------------------------------------------------
module tb_tof_frame_streamer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_wea;
   logic [2:0]  wr_index;
   logic        mem_en,  mem_en3;
   logic [4:0]  mem_addr, mem_addr3;
   logic [15:0] mem_dout, mem_dout3;
   logic [7:0]  m_tdata, m_tdata3;
   logic        m_tvalid, m_tvalid3;
   logic        m_tready;
   logic        m_tready3 = 1'b1;
   logic        m_tlast, m_tlast3;
   logic        busy, busy3;
   logic [7:0]  pending, pending3;

   logic [15:0] mem [32];
   logic [15:0] rd1, p3_0, p3_1, p3_2;
   logic [7:0]  exp1 [10];
   logic [8:0]  sb [$];

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  hs_cnt  = 0;
   int  n3      = 0;
   logic bp_en  = 1'b0;
   logic chk3   = 1'b0;

   always #5 clk = ~clk;

   tof_frame_streamer u_dut (
      .clk(clk), .reset(reset), .wr_wea(wr_wea), .wr_index(wr_index),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .busy(busy), .pending(pending)
   );

   tof_frame_streamer #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .wr_wea(wr_wea), .wr_index(wr_index),
      .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_dout(mem_dout3),
      .m_tdata(m_tdata3), .m_tvalid(m_tvalid3), .m_tready(m_tready3), .m_tlast(m_tlast3),
      .busy(busy3), .pending(pending3)
   );

   // BRAM models: 1-cycle and 3-cycle read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en)  rd1  <= mem[mem_addr];
      if (mem_en3) p3_0 <= mem[mem_addr3];
      p3_1 <= p3_0;
      p3_2 <= p3_1;
   end
   assign mem_dout  = rd1;
   assign mem_dout3 = p3_2;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_pkt(input int idx);
      logic [7:0]  cs;
      logic [7:0]  hb;
      logic [15:0] w;
      hb = 8'hA0 | 8'(idx);
      cs = hb;
      sb.push_back({1'b0, hb});
      for (int wi = 0; wi < 4; wi++) begin
         w = mem[idx * 4 + wi];
         sb.push_back({1'b0, w[15:8]});
         sb.push_back({1'b0, w[7:0]});
         cs = cs ^ w[15:8] ^ w[7:0];
      end
      sb.push_back({1'b1, cs});
   endtask

   task automatic do_write(input int idx, input int len);
      @(posedge clk); #1;
      wr_wea   = 1'b1;
      wr_index = 3'(idx);
      repeat (len - 1) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      wr_wea = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 600 && !done; k++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && !busy) done = 1'b1;
      end
      check_eq(tag, {31'd0, done}, 32'd1);
      @(negedge clk);
      check_eq({tag, "_pending"}, {24'd0, pending}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Backpressure source: random ready when enabled, otherwise always ready.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor for u_dut: scoreboard pop on handshake, stall stability, read latency.
   initial begin
      logic [8:0] held;
      logic [8:0] e;
      logic       stall_prev;
      logic       armed;
      int         en_cyc;
      stall_prev = 1'b0;
      armed      = 1'b0;
      en_cyc     = 0;
      held       = 9'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_prev = 1'b0;
            armed      = 1'b0;
         end else begin
            if (stall_prev && m_tvalid) check_eq("stall_stable", {23'd0, m_tlast, m_tdata}, {23'd0, held});
            if (armed && m_tvalid) begin
               check_eq("rd_gap", 32'(cyc - en_cyc), 32'd2);
               armed = 1'b0;
            end
            if (mem_en) begin
               en_cyc = cyc;
               armed  = 1'b1;
            end
            if (m_tvalid && m_tready) begin
               hs_cnt++;
               if (sb.size() == 0) begin
                  check_eq("extra_byte", {23'd0, m_tlast, m_tdata}, 32'hDEAD_0000);
               end else begin
                  e = sb.pop_front();
                  check_eq("byte", {23'd0, m_tlast, m_tdata}, {23'd0, e});
               end
            end
            stall_prev = m_tvalid && !m_tready;
            held       = {m_tlast, m_tdata};
         end
      end
   end

   // Monitor for u_dut3 (always ready): first packet bytes and 3-cycle read gap.
   initial begin
      logic armed3;
      int   en_cyc3;
      armed3  = 1'b0;
      en_cyc3 = 0;
      forever begin
         @(negedge clk);
         if (!reset && chk3) begin
            // mem_en in cycle t, buffer load at end of t+3, first SEND byte in t+4
            if (armed3 && m_tvalid3) begin
               check_eq("rdlat3_gap", 32'(cyc - en_cyc3), 32'd4);
               armed3 = 1'b0;
            end
            if (mem_en3) begin
               en_cyc3 = cyc;
               armed3  = 1'b1;
            end
            if (m_tvalid3 && n3 < 10) begin
               check_eq("rdlat3_byte", {23'd0, m_tlast3, m_tdata3}, {23'd0, (n3 == 9), exp1[n3]});
               n3++;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic found;
      int   base;
      for (int i = 0; i < 32; i++) mem[i] = 16'(i * 1831 + 23055);
      mem[12] = 16'h1122; mem[13] = 16'h3344; mem[14] = 16'h5566; mem[15] = 16'h7788;
      exp1[0] = 8'hA3; exp1[1] = 8'h11; exp1[2] = 8'h22; exp1[3] = 8'h33; exp1[4] = 8'h44;
      exp1[5] = 8'h55; exp1[6] = 8'h66; exp1[7] = 8'h77; exp1[8] = 8'h88; exp1[9] = 8'h2B;

      reset    = 1'b1;
      wr_wea   = 1'b0;
      wr_index = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tvalid",  {31'd0, m_tvalid}, 32'd0);
      check_eq("rst_tlast",   {31'd0, m_tlast},  32'd0);
      check_eq("rst_tdata",   {24'd0, m_tdata},  32'd0);
      check_eq("rst_mem_en",  {31'd0, mem_en},   32'd0);
      check_eq("rst_mem_addr",{27'd0, mem_addr}, 32'd0);
      check_eq("rst_busy",    {31'd0, busy},     32'd0);
      check_eq("rst_pending", {24'd0, pending},  32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single record, slot 3, both latency builds.
      chk3 = 1'b1;
      for (int i = 0; i < 10; i++) sb.push_back({(i == 9), exp1[i]});
      do_write(3, 2);
      wait_done("single");
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(posedge clk); #1;
         if (n3 == 10 && !busy3) found = 1'b1;
      end
      check_eq("rdlat3_done", {31'd0, found}, 32'd1);
      chk3 = 1'b0;

      // Backpressure: same record, random ready.
      bp_en = 1'b1;
      push_pkt(3);
      do_write(3, 2);
      wait_done("backpressure");
      bp_en = 1'b0;
      repeat (2) @(posedge clk); #1;

      // Round-robin: packet 5 leaves rr_ptr at 6; 1, 5, 6 flagged meanwhile.
      push_pkt(5); push_pkt(6); push_pkt(1); push_pkt(5);
      do_write(5, 1);
      do_write(1, 1);
      do_write(5, 3);
      do_write(6, 2);
      wait_done("round_robin");

      // Re-arm: second write to 2 ends on the cycle 2 is granted.
      push_pkt(0); push_pkt(2); push_pkt(2);
      do_write(0, 1);
      do_write(2, 1);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (m_tvalid && m_tlast && m_tready) found = 1'b1;
      end
      check_eq("rearm_sync", {31'd0, found}, 32'd1);
      wr_index = 3'd2;
      wr_wea   = 1'b1;
      @(negedge clk);
      wr_wea   = 1'b0;
      @(posedge clk); #1;
      wait_done("rearm");

      // Reset after the 4th byte handshake of a packet for sensor 4.
      push_pkt(4);
      base = hs_cnt;
      do_write(4, 1);
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         if (hs_cnt >= base + 4) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check_eq("mid_reset_sync", {31'd0, found}, 32'd1);
      reset = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_reset_tvalid",  {31'd0, m_tvalid}, 32'd0);
      check_eq("mid_reset_pending", {24'd0, pending},  32'd0);
      check_eq("mid_reset_busy",    {31'd0, busy},     32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      push_pkt(0);
      do_write(0, 2);
      wait_done("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
